scr_ram_arbiter: RTL and testbench

- Shares the single-port 256x10 scratch RAM between two requesters:
  - Port A: CPU, priority requester.
  - Port B: I/O / debug loader, background requester.
- Fixed priority to A, with a starvation guard that forces a grant to B after MAX_WAIT consecutive denied cycles.
- Registers read data per port.
- Sits between the CPU/debug logic and the scratch RAM; drives the RAM's address, write-enable and data-in, and samples its asynchronous data-out.

---
 rtl/scr_arb_pkg.sv | 20 ++
 rtl/scr_port_rdreg.sv | 32 +++
 rtl/scr_ram_arbiter.sv | 155 +++++++++++++++
 tb/tb_scr_ram_arbiter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/scr_arb_pkg.sv
// Shared types and constants for the scratch RAM arbiter.
package scr_arb_pkg;

  localparam int unsigned SCR_ADDR_W = 8;
  localparam int unsigned SCR_DATA_W = 10;
  localparam int unsigned SCR_DEPTH  = 256;

  typedef enum logic {
    CLEAR,
    RUN
  } arb_state_t;

  typedef struct packed {
    logic                  req;
    logic                  we;
    logic [SCR_ADDR_W-1:0] addr;
    logic [SCR_DATA_W-1:0] din;
  } scr_req_t;

endpackage

// File: rtl/scr_port_rdreg.sv
// Per-port read-data capture register with a one-cycle valid pulse.
module scr_port_rdreg #(
  parameter int unsigned DATA_W = 10
) (
  input  logic              clk,
  input  logic              rst_i,
  input  logic              rd_en_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic [DATA_W-1:0] dout_o,
  output logic              rvalid_o
);

  logic [DATA_W-1:0] dout_q;
  logic              rvalid_q;

  // Capture RAM data on a granted read; data holds until the next one.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      dout_q   <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= rd_en_i;
      if (rd_en_i) begin
        dout_q <= rdata_i;
      end
    end
  end

  assign dout_o   = dout_q;
  assign rvalid_o = rvalid_q;

endmodule

// File: rtl/scr_ram_arbiter.sv
// Two-port arbiter for the single-port scratch RAM: port A has fixed
// priority, port B is force-granted after MAX_WAIT denied cycles.
// Optional SCR_ARB_CLEAR_EN: zero-fill the RAM after every reset before
// accepting requests.
module scr_ram_arbiter
  import scr_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = SCR_ADDR_W,
  parameter int unsigned DATA_W   = SCR_DATA_W,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              A_REQ,
  input  logic              A_WE,
  input  logic [ADDR_W-1:0] A_ADDR,
  input  logic [DATA_W-1:0] A_DIN,
  output logic              A_GNT,
  output logic [DATA_W-1:0] A_DOUT,
  output logic              A_RVALID,
  input  logic              B_REQ,
  input  logic              B_WE,
  input  logic [ADDR_W-1:0] B_ADDR,
  input  logic [DATA_W-1:0] B_DIN,
  output logic              B_GNT,
  output logic [DATA_W-1:0] B_DOUT,
  output logic              B_RVALID,
  output logic [ADDR_W-1:0] SCR_ADDR,
  output logic              SCR_WE,
  output logic [DATA_W-1:0] SCR_DIN,
  input  logic [DATA_W-1:0] SCR_DOUT,
  output logic              BUSY,
  output logic [15:0]       CONFLICT_CNT
);

  localparam int unsigned WAIT_W = 4;
  localparam int unsigned CNT_W  = 16;
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);
`ifdef SCR_ARB_CLEAR_EN
  localparam arb_state_t RST_STATE = CLEAR;
`else
  localparam arb_state_t RST_STATE = RUN;
`endif

  arb_state_t        state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
`ifdef SCR_ARB_CLEAR_EN
  logic [ADDR_W-1:0] ptr_q, ptr_d;
`endif

  scr_req_t          a_s, b_s;
  logic              a_gnt_c, b_gnt_c, busy_c, scr_we_c;
  logic [ADDR_W-1:0] scr_addr_c;
  logic [DATA_W-1:0] scr_din_c;

  assign a_s = '{req: A_REQ, we: A_WE, addr: SCR_ADDR_W'(A_ADDR), din: SCR_DATA_W'(A_DIN)};
  assign b_s = '{req: B_REQ, we: B_WE, addr: SCR_ADDR_W'(B_ADDR), din: SCR_DATA_W'(B_DIN)};

  // State, starvation counter, conflict counter and clear pointer.
  always_ff @(posedge clk) begin
    if (RST) begin
      state_q <= RST_STATE;
      wait_q  <= '0;
      cnt_q   <= '0;
`ifdef SCR_ARB_CLEAR_EN
      ptr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
`ifdef SCR_ARB_CLEAR_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  // Next state, arbitration and RAM-side mux.
  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    cnt_d      = cnt_q;
`ifdef SCR_ARB_CLEAR_EN
    ptr_d      = ptr_q;
`endif
    a_gnt_c    = 1'b0;
    b_gnt_c    = 1'b0;
    busy_c     = 1'b0;
    scr_we_c   = 1'b0;
    scr_addr_c = ADDR_W'(a_s.addr);
    scr_din_c  = DATA_W'(a_s.din);

    case (state_q)
`ifdef SCR_ARB_CLEAR_EN
      CLEAR: begin
        busy_c     = 1'b1;
        scr_we_c   = 1'b1;
        scr_din_c  = '0;
        scr_addr_c = ptr_q;
        ptr_d      = ptr_q + ADDR_W'(1);
        if (ptr_q == {ADDR_W{1'b1}}) begin
          state_d = RUN;
        end
      end
`endif
      default: begin
        b_gnt_c = b_s.req && (!a_s.req || (wait_q == WAIT_MAX));
        a_gnt_c = a_s.req && !b_gnt_c;
        if (b_gnt_c) begin
          scr_we_c   = b_s.we;
          scr_addr_c = ADDR_W'(b_s.addr);
          scr_din_c  = DATA_W'(b_s.din);
        end else if (a_gnt_c) begin
          scr_we_c   = a_s.we;
        end
        if (!b_s.req || b_gnt_c) begin
          wait_d = '0;
        end else if (wait_q < WAIT_MAX) begin
          wait_d = wait_q + WAIT_W'(1);
        end
        if (a_s.req && b_s.req && (cnt_q != {CNT_W{1'b1}})) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase
  end

  scr_port_rdreg #(.DATA_W(DATA_W)) u_rdreg_a (
    .clk      (clk),
    .rst_i    (RST),
    .rd_en_i  (a_gnt_c && !A_WE),
    .rdata_i  (SCR_DOUT),
    .dout_o   (A_DOUT),
    .rvalid_o (A_RVALID)
  );

  scr_port_rdreg #(.DATA_W(DATA_W)) u_rdreg_b (
    .clk      (clk),
    .rst_i    (RST),
    .rd_en_i  (b_gnt_c && !B_WE),
    .rdata_i  (SCR_DOUT),
    .dout_o   (B_DOUT),
    .rvalid_o (B_RVALID)
  );

  assign A_GNT        = a_gnt_c;
  assign B_GNT        = b_gnt_c;
  assign SCR_ADDR     = scr_addr_c;
  assign SCR_WE       = scr_we_c;
  assign SCR_DIN      = scr_din_c;
  assign BUSY         = busy_c;
  assign CONFLICT_CNT = cnt_q;

endmodule

// File: tb/tb_scr_ram_arbiter.sv
// Bench for scr_ram_arbiter: behavioural RAM, randomized traffic and a
// rule-level reference model of grants, RAM contents and counters.
module tb_scr_ram_arbiter;
  import scr_arb_pkg::*;

  localparam int unsigned AW    = 8;
  localparam int unsigned DW    = 10;
  localparam int          MW    = 4;
  localparam int          DEPTH = 256;
`ifdef SCR_ARB_CLEAR_EN
  localparam int          CLR_LEN = DEPTH;
  localparam logic [DW-1:0] PRE   = 10'h3FF;
`else
  localparam int          CLR_LEN = 0;
  localparam logic [DW-1:0] PRE   = 10'h000;
`endif

  logic          clk = 1'b0;
  logic          RST;
  logic          A_REQ, A_WE, B_REQ, B_WE;
  logic [AW-1:0] A_ADDR, B_ADDR, SCR_ADDR;
  logic [DW-1:0] A_DIN, B_DIN, A_DOUT, B_DOUT, SCR_DIN, SCR_DOUT;
  logic          A_GNT, B_GNT, A_RVALID, B_RVALID, SCR_WE, BUSY;
  logic [15:0]   CONFLICT_CNT;

  always #5 clk = ~clk;

  scr_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
    .clk(clk), .RST(RST),
    .A_REQ(A_REQ), .A_WE(A_WE), .A_ADDR(A_ADDR), .A_DIN(A_DIN),
    .A_GNT(A_GNT), .A_DOUT(A_DOUT), .A_RVALID(A_RVALID),
    .B_REQ(B_REQ), .B_WE(B_WE), .B_ADDR(B_ADDR), .B_DIN(B_DIN),
    .B_GNT(B_GNT), .B_DOUT(B_DOUT), .B_RVALID(B_RVALID),
    .SCR_ADDR(SCR_ADDR), .SCR_WE(SCR_WE), .SCR_DIN(SCR_DIN), .SCR_DOUT(SCR_DOUT),
    .BUSY(BUSY), .CONFLICT_CNT(CONFLICT_CNT)
  );

  // Behavioural scratch RAM: synchronous write, asynchronous read.
  logic [DW-1:0] ram [DEPTH];
  logic          preload_en = 1'b0;
  logic [DW-1:0] preload_val = '0;
  always @(posedge clk) begin
    if (preload_en) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= preload_val;
    end else if (SCR_WE) begin
      ram[SCR_ADDR] <= SCR_DIN;
    end
  end
  assign SCR_DOUT = ram[SCR_ADDR];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int busy_seen = 0;

  // Reference model state.
  logic [DW-1:0] ref_mem [DEPTH];
  int            m_wait, m_cc, m_clear_left;
  logic [DW-1:0] m_adout, m_bdout;
  bit            m_arv, m_brv;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic idle_inputs();
    A_REQ = 0; A_WE = 0; A_ADDR = '0; A_DIN = '0;
    B_REQ = 0; B_WE = 0; B_ADDR = '0; B_DIN = '0;
  endtask

  task automatic do_reset(input bit preload, input logic [DW-1:0] pval);
    idle_inputs();
    RST = 1'b1;
    preload_en = preload;
    preload_val = pval;
    @(posedge clk); #1;
    RST = 1'b0;
    preload_en = 1'b0;
    if (preload) for (int i = 0; i < DEPTH; i++) ref_mem[i] = pval;
    m_wait = 0; m_cc = 0; m_clear_left = CLR_LEN;
    m_adout = '0; m_bdout = '0; m_arv = 0; m_brv = 0;
  endtask

  // One clock: predict and compare, then advance the model across the edge.
  task automatic cycle(output bit ag, output bit bg);
    bit eag, ebg, ebusy, ewe;
    logic [AW-1:0] eaddr;
    logic [DW-1:0] edin;
    #3;
    if (m_clear_left > 0) begin
      eag = 0; ebg = 0; ebusy = 1; ewe = 1;
      eaddr = AW'(DEPTH - m_clear_left); edin = '0;
    end else begin
      ebusy = 0;
      ebg = B_REQ && (!A_REQ || m_wait == MW);
      eag = A_REQ && !ebg;
      if (ebg) begin
        ewe = B_WE; eaddr = B_ADDR; edin = B_DIN;
      end else if (eag) begin
        ewe = A_WE; eaddr = A_ADDR; edin = A_DIN;
      end else begin
        ewe = 0; eaddr = A_ADDR; edin = A_DIN;
      end
    end
    chk("a_gnt", A_GNT, eag);
    chk("b_gnt", B_GNT, ebg);
    chk("busy", BUSY, ebusy);
    chk("scr_we", SCR_WE, ewe);
    if (ewe || eag || ebg) begin
      chk("scr_addr", SCR_ADDR, eaddr);
      chk("scr_din", SCR_DIN, edin);
    end
    chk("a_dout", A_DOUT, m_adout);
    chk("a_rvalid", A_RVALID, m_arv);
    chk("b_dout", B_DOUT, m_bdout);
    chk("b_rvalid", B_RVALID, m_brv);
    chk("conflict_cnt", CONFLICT_CNT, m_cc);
    if (BUSY) busy_seen++;

    if (m_clear_left > 0) begin
      ref_mem[eaddr] = '0;
      m_clear_left--;
      m_arv = 0; m_brv = 0;
    end else begin
      m_arv = eag && !A_WE;
      m_brv = ebg && !B_WE;
      if (m_arv) m_adout = ref_mem[A_ADDR];
      if (m_brv) m_bdout = ref_mem[B_ADDR];
      if ((eag || ebg) && ewe) ref_mem[eaddr] = edin;
      if (B_REQ && !ebg) m_wait = (m_wait + 1 > MW) ? MW : m_wait + 1;
      else m_wait = 0;
      if (A_REQ && B_REQ && m_cc < 65535) m_cc++;
    end
    ag = eag; bg = ebg;
    cyc++;
    @(posedge clk); #1;
  endtask

  task automatic rand_traffic(input int n, input int pct);
    bit ag, bg;
    for (int i = 0; i < n; i++) begin
      if (!A_REQ || ag) begin
        A_REQ = ($urandom_range(0, 99) < pct); A_WE = $urandom_range(0, 1);
        A_ADDR = AW'($urandom_range(0, 15)); A_DIN = DW'($urandom);
      end
      if (!B_REQ || bg) begin
        B_REQ = ($urandom_range(0, 99) < pct); B_WE = $urandom_range(0, 1);
        B_ADDR = AW'($urandom_range(0, 15)); B_DIN = DW'($urandom);
      end
      cycle(ag, bg);
    end
  endtask

  initial begin
    bit ag, bg;
    bit [14:0] apat, bpat;
    int cc0;
    logic [AW-1:0] raddr [3];
    raddr[0] = 8'h00; raddr[1] = 8'h7F; raddr[2] = 8'hFF;

    // Reset with preloaded RAM; a held read must wait out any clear.
    do_reset(1'b1, PRE);
    busy_seen = 0;
    A_REQ = 1; A_WE = 0; A_ADDR = raddr[0];
    ag = 0;
    while (!ag) cycle(ag, bg);
    chk("busy_len", busy_seen, CLR_LEN);
    for (int i = 1; i < 3; i++) begin
      A_ADDR = raddr[i];
      cycle(ag, bg);
    end
    idle_inputs();
    cycle(ag, bg);
    chk("a_clr_read", A_DOUT, 10'h000);

    // A write then read back.
    A_REQ = 1; A_WE = 1; A_ADDR = 8'h10; A_DIN = 10'h2A5;
    cycle(ag, bg);
    A_WE = 0;
    cycle(ag, bg);
    chk("a_wr_rd", A_DOUT, 10'h2A5);
    chk("a_wr_rv", A_RVALID, 1'b1);
    idle_inputs();
    cycle(ag, bg);

    // Starvation guard with both requesters held.
    cc0 = m_cc;
    A_REQ = 1; A_WE = 0; A_ADDR = 8'h01;
    B_REQ = 1; B_WE = 0; B_ADDR = 8'h02;
    for (int i = 0; i < 15; i++) begin
      cycle(ag, bg);
      apat[i] = ag; bpat[i] = bg;
    end
    chk("starve_b", bpat, 15'b100001000010000);
    chk("starve_a", apat, 15'b011110111101111);
    chk("starve_cc", CONFLICT_CNT, cc0 + 15);
    idle_inputs();
    cycle(ag, bg);

    // Same-address conflict: A writes, B then reads A's data.
    A_REQ = 1; A_WE = 1; A_ADDR = 8'h20; A_DIN = 10'h111;
    B_REQ = 1; B_WE = 0; B_ADDR = 8'h20;
    cycle(ag, bg);
    chk("conf_first_a", ag, 1'b1);
    A_REQ = 0;
    cycle(ag, bg);
    chk("conf_then_b", bg, 1'b1);
    B_REQ = 0;
    cycle(ag, bg);
    chk("conf_b_dout", B_DOUT, 10'h111);

    // Randomized traffic.
    rand_traffic(2000, 70);

    // Reset halfway through a clear sequence, then again mid-clear.
    do_reset(1'b0, '0);
    rand_traffic(128, 60);
    do_reset(1'b0, '0);
    busy_seen = 0;
    rand_traffic(CLR_LEN + 200, 60);
    chk("busy_len2", busy_seen, CLR_LEN);

    // Conflict counter saturation.
    A_REQ = 1; A_WE = 0; A_ADDR = 8'h03;
    B_REQ = 1; B_WE = 0; B_ADDR = 8'h04;
    for (int i = 0; i < 70000; i++) cycle(ag, bg);
    chk("cc_sat", CONFLICT_CNT, 32'h0000FFFF);
    idle_inputs();
    cycle(ag, bg);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
